// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pkg
// Brief    : Shared state encoding and code points for the instruction fetch unit.
// Revision : 1.0
// ============================================================================
package ifu_pkg;

  typedef enum logic [2:0] {
    AR       = 3'd0,
    R        = 3'd1,
    HOLD     = 3'd2,
    WAIT_NPC = 3'd3,
    FAULT    = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_BUSERR   = 2'b10;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_if.sv
`default_nettype none
// ============================================================================
// Module   : ifu_if
// Brief    : AXI4-Lite AR/R channel, IFU->IDU handshake and write-back next-PC bundle.
// Revision : 1.0
// ============================================================================
interface ifu_if #(
  parameter int XLEN = 32
) ();

  logic [XLEN-1:0] araddr;
  logic            arvalid;
  logic            arready;
  logic [XLEN-1:0] rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] pc;
  logic            IFU_valid;
  logic            IDU_ready;
  logic [XLEN-1:0] dnpc;
  logic            npc_valid;
  logic            fault;
  logic [1:0]      fault_cause;

  modport master (
    output araddr, arvalid, rready, inst, pc, IFU_valid, fault, fault_cause,
    input  arready, rdata, rresp, rvalid, IDU_ready, dnpc, npc_valid
  );

  modport slave (
    input  araddr, arvalid, rready, inst, pc, IFU_valid, fault, fault_cause,
    output arready, rdata, rresp, rvalid, IDU_ready, dnpc, npc_valid
  );

endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Brief    : Non-pipelined fetch stage: one AXI4-Lite read per PC, handed to decode.
// Revision : 1.0
// ============================================================================
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  wire logic clk,
  input  wire logic rst,
  ifu_if.master     bus
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic            r_fault;
  logic [1:0]      r_fault_cause;
  logic            w_arvalid;
  logic            w_rready;
  logic            w_ifu_valid;
  logic            w_r_done;
  logic            w_npc_take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= AR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_ifu_valid = 1'b0;
    case (r_state)
      AR: begin
        w_arvalid = 1'b1;
        if (bus.arready) begin
          w_state_nxt = R;
        end
      end
      R: begin
        w_rready = 1'b1;
        if (bus.rvalid) begin
          w_state_nxt = (bus.rresp == RESP_OKAY) ? HOLD : FAULT;
        end
      end
      HOLD: begin
        w_ifu_valid = 1'b1;
        if (bus.IDU_ready) begin
          w_state_nxt = WAIT_NPC;
        end
      end
      WAIT_NPC: begin
        if (bus.npc_valid) begin
          w_state_nxt = is_aligned(bus.dnpc[1:0]) ? AR : FAULT;
        end
      end
      FAULT: begin
        w_state_nxt = FAULT;
      end
      default: begin
        w_state_nxt = AR;
      end
    endcase
  end

  assign w_r_done   = (r_state == R) && bus.rvalid;
  assign w_npc_take = (r_state == WAIT_NPC) && bus.npc_valid;

  // A misaligned dnpc is still latched into pc so the offending address is visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_inst        <= '0;
      r_fault       <= 1'b0;
      r_fault_cause <= FC_NONE;
    end else begin
      if (w_r_done) begin
        if (bus.rresp == RESP_OKAY) begin
          r_inst <= bus.rdata;
        end else begin
          r_fault       <= 1'b1;
          r_fault_cause <= FC_BUSERR;
        end
      end
      if (w_npc_take) begin
        r_pc <= bus.dnpc;
        if (!is_aligned(bus.dnpc[1:0])) begin
          r_fault       <= 1'b1;
          r_fault_cause <= FC_MISALIGN;
        end
      end
    end
  end

  // State resets to AR, so arvalid is gated by rst to stay low during reset.
  assign bus.arvalid     = w_arvalid & rst;
  assign bus.araddr      = r_pc;
  assign bus.rready      = w_rready;
  assign bus.IFU_valid   = w_ifu_valid;
  assign bus.inst        = r_inst;
  assign bus.pc          = r_pc;
  assign bus.fault       = r_fault;
  assign bus.fault_cause = r_fault_cause;

endmodule
`default_nettype wire
